// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM slot arbiter.
// Build option: VRAM_ARB_BLANK_FREE_EN opens every blank phase 0-6 to CPU
// starts; without it the CPU starts only at phase 6.
package vram_arb_pkg;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 9;
    localparam int unsigned PH_W   = 3;

    // Display window opens at H=256; being a multiple of 8 it always opens on phase 0.
    localparam logic [CNT_W-1:0] H_ACT_START = 9'd256;

    localparam logic [PH_W-1:0] PH_REN_LAST  = 3'd5;
    localparam logic [PH_W-1:0] PH_CPU_START = 3'd6;
    localparam logic [PH_W-1:0] PH_LAST      = 3'd7;

`ifdef VRAM_ARB_BLANK_FREE_EN
    localparam bit BLANK_FREE = 1'b1;
`else
    localparam bit BLANK_FREE = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_ACK     = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

endpackage

// File: rtl/vram_slot_decoder.sv
// Slot decoder: classifies the current absolute H/V position into slot phase,
// display-active, renderer-slot and CPU-start permission. Purely combinational.
// Honours VRAM_ARB_BLANK_FREE_EN through vram_arb_pkg::BLANK_FREE.
module vram_slot_decoder
    import vram_arb_pkg::*;
#(
    parameter logic [CNT_W-1:0] V_ACT_FIRST = 9'd272,
    parameter logic [CNT_W-1:0] V_ACT_LAST  = 9'd495
) (
    input  logic [CNT_W-1:0] i_ABS_H_CNTR,
    input  logic [CNT_W-1:0] i_ABS_V_CNTR,
    output logic [PH_W-1:0]  o_PHASE,
    output logic             o_ACTIVE,
    output logic             o_REN_SLOT,
    output logic             o_CPU_START_OK
);

    // Decode phase, display window and slot ownership rights for this tick.
    always_comb begin
        o_PHASE    = i_ABS_H_CNTR[PH_W-1:0];
        o_ACTIVE   = (i_ABS_H_CNTR >= H_ACT_START) &&
                     (i_ABS_V_CNTR >= V_ACT_FIRST) &&
                     (i_ABS_V_CNTR <= V_ACT_LAST);
        o_REN_SLOT = o_ACTIVE && (o_PHASE <= PH_REN_LAST);
        // Phase 7 never starts an access, so the strobe (start+1) can never
        // fall on phase 0 of a renderer group.
        o_CPU_START_OK = (o_PHASE == PH_CPU_START) ||
                         (!o_ACTIVE && (o_PHASE != PH_LAST) && BLANK_FREE);
    end

endmodule

// File: rtl/vram_slot_arbiter.sv
// VRAM slot arbiter: shares the single 8-bit video RAM port between the
// fixed-slot tile renderer and CPU req/ack accesses. Renderer slots are never
// delayed; the CPU gets reserved phase-6 slots (and blank slots when
// VRAM_ARB_BLANK_FREE_EN is defined).
module vram_slot_arbiter
    import vram_arb_pkg::*;
#(
    parameter logic [CNT_W-1:0] V_ACT_FIRST = 9'd272,
    parameter logic [CNT_W-1:0] V_ACT_LAST  = 9'd495
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_INITRST_n,
    input  logic              i_EMU_CLK6MPCEN_n,
    input  logic [CNT_W-1:0]  i_ABS_H_CNTR,
    input  logic [CNT_W-1:0]  i_ABS_V_CNTR,
    input  logic [ADDR_W-1:0] i_REN_ADDR,
    output logic [DATA_W-1:0] o_REN_DOUT,
    output logic              o_REN_DVALID,
    output logic [PH_W-1:0]   o_REN_PHASE,
    input  logic              i_CPU_REQ,
    input  logic              i_CPU_WR,
    input  logic [ADDR_W-1:0] i_CPU_ADDR,
    input  logic [DATA_W-1:0] i_CPU_DIN,
    output logic              o_CPU_ACK,
    output logic [DATA_W-1:0] o_CPU_DOUT,
    output logic [ADDR_W-1:0] o_RAM_ADDR,
    output logic [DATA_W-1:0] o_RAM_DOUT,
    input  logic [DATA_W-1:0] i_RAM_DIN,
    output logic              o_RAM_CS_n,
    output logic              o_RAM_WE_n
);

    logic [PH_W-1:0]   w_phase;
    logic              w_active;
    logic              w_ren_slot;
    logic              w_cpu_start_ok;
    logic              w_tick;
    logic              w_ren_own;

    arb_state_t        r_state;
    arb_state_t        w_cur_state;
    arb_state_t        w_next_state;
    logic              w_cpu_own;
    logic              w_cpu_we;
    logic              w_cpu_ack;
    logic              w_cpu_rd_cap;

    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_dout;
    logic              w_ram_cs_n;
    logic              w_ram_we_n;
    logic [ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0] r_last_dout;

    logic              r_ren_dvalid;
    logic [DATA_W-1:0] r_ren_dout;
    logic [PH_W-1:0]   r_ren_phase;
    logic [DATA_W-1:0] r_cpu_dout;

    vram_slot_decoder #(
        .V_ACT_FIRST (V_ACT_FIRST),
        .V_ACT_LAST  (V_ACT_LAST)
    ) u_slot_decoder (
        .i_ABS_H_CNTR   (i_ABS_H_CNTR),
        .i_ABS_V_CNTR   (i_ABS_V_CNTR),
        .o_PHASE        (w_phase),
        .o_ACTIVE       (w_active),
        .o_REN_SLOT     (w_ren_slot),
        .o_CPU_START_OK (w_cpu_start_ok)
    );

    assign w_tick    = ~i_EMU_CLK6MPCEN_n;
    assign w_ren_own = w_active & w_ren_slot;

    // CPU access sequencing: current-state decode, next state and port requests.
    always_comb begin
        // SETUP is the start tick itself: the permitted phase is only known in
        // that tick, so the IDLE->SETUP step is taken combinationally and the
        // register next holds STROBE. This keeps the strobe at start+1.
        w_cur_state = r_state;
        if ((r_state == ST_IDLE) && i_CPU_REQ && w_cpu_start_ok) begin
            w_cur_state = ST_SETUP;
        end

        w_next_state = w_cur_state;
        w_cpu_own    = 1'b0;
        w_cpu_we     = 1'b0;
        w_cpu_ack    = 1'b0;
        w_cpu_rd_cap = 1'b0;

        case (w_cur_state)
            ST_IDLE: begin
                w_next_state = ST_IDLE;
            end
            ST_SETUP: begin
                w_cpu_own    = 1'b1;
                w_next_state = ST_STROBE;
            end
            ST_STROBE: begin
                w_cpu_own    = 1'b1;
                w_cpu_we     = i_CPU_WR;
                w_cpu_rd_cap = ~i_CPU_WR;
                w_next_state = ST_ACK;
            end
            ST_ACK: begin
                w_cpu_ack    = 1'b1;
                w_next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A request still held after ack is never served again.
                if (!i_CPU_REQ) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state register, advancing on pixel ticks only.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            r_state <= ST_IDLE;
        end else if (w_tick) begin
            r_state <= w_next_state;
        end
    end

    // RAM port mux: renderer first, then CPU, otherwise deselected with held bus.
    always_comb begin
        w_ram_addr = r_last_addr;
        w_ram_dout = r_last_dout;
        w_ram_cs_n = 1'b1;
        w_ram_we_n = 1'b1;
        // Reset deselects the RAM at once, aborting any strobe in flight.
        if (i_EMU_INITRST_n) begin
            if (w_ren_own) begin
                w_ram_addr = i_REN_ADDR;
                w_ram_cs_n = 1'b0;
            end else if (w_cpu_own) begin
                w_ram_addr = i_CPU_ADDR;
                w_ram_dout = i_CPU_DIN;
                w_ram_cs_n = 1'b0;
                w_ram_we_n = ~w_cpu_we;
            end
        end
    end

    // Hold the last driven address and write data while nobody owns the port.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            r_last_addr <= '0;
            r_last_dout <= '0;
        end else if (w_tick) begin
            r_last_addr <= w_ram_addr;
            r_last_dout <= w_ram_dout;
        end
    end

    // Capture renderer fetch data; it is presented during the following tick.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            r_ren_dvalid <= 1'b0;
            r_ren_dout   <= '0;
            r_ren_phase  <= '0;
        end else if (w_tick) begin
            r_ren_dvalid <= w_ren_own;
            if (w_ren_own) begin
                r_ren_dout  <= i_RAM_DIN;
                r_ren_phase <= w_phase;
            end
        end
    end

    // Latch CPU read data at the strobe tick; held until the next read.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            r_cpu_dout <= '0;
        end else if (w_tick && w_cpu_rd_cap) begin
            r_cpu_dout <= i_RAM_DIN;
        end
    end

    assign o_RAM_ADDR   = w_ram_addr;
    assign o_RAM_DOUT   = w_ram_dout;
    assign o_RAM_CS_n   = w_ram_cs_n;
    assign o_RAM_WE_n   = w_ram_we_n;
    assign o_CPU_ACK    = w_cpu_ack;
    assign o_CPU_DOUT   = r_cpu_dout;
    assign o_REN_DVALID = r_ren_dvalid;
    assign o_REN_DOUT   = r_ren_dout;
    assign o_REN_PHASE  = r_ren_phase;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Testbench for vram_slot_arbiter. Follows VRAM_ARB_BLANK_FREE_EN the same way
// as the design build.
module tb_vram_slot_arbiter;

    localparam logic [8:0] V_FIRST = 9'd272;
    localparam logic [8:0] V_LAST  = 9'd495;
`ifdef VRAM_ARB_BLANK_FREE_EN
    localparam bit BF = 1'b1;
`else
    localparam bit BF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen_n;
    logic [8:0]  h, v;
    logic [12:0] ren_addr;
    logic        cpu_req, cpu_wr;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  ren_dout, cpu_dout, ram_dout, ram_din;
    logic        ren_dvalid, cpu_ack, ram_cs_n, ram_we_n;
    logic [2:0]  ren_phase;
    logic [12:0] ram_addr;

    logic [7:0]  ram [0:8191];
    assign ram_din = ram[ram_addr];

    always #5 clk = ~clk;

    vram_slot_arbiter #(
        .V_ACT_FIRST (V_FIRST),
        .V_ACT_LAST  (V_LAST)
    ) dut (
        .i_EMU_MCLK        (clk),
        .i_EMU_INITRST_n   (rst_n),
        .i_EMU_CLK6MPCEN_n (cen_n),
        .i_ABS_H_CNTR      (h),
        .i_ABS_V_CNTR      (v),
        .i_REN_ADDR        (ren_addr),
        .o_REN_DOUT        (ren_dout),
        .o_REN_DVALID      (ren_dvalid),
        .o_REN_PHASE       (ren_phase),
        .i_CPU_REQ         (cpu_req),
        .i_CPU_WR          (cpu_wr),
        .i_CPU_ADDR        (cpu_addr),
        .i_CPU_DIN         (cpu_din),
        .o_CPU_ACK         (cpu_ack),
        .o_CPU_DOUT        (cpu_dout),
        .o_RAM_ADDR        (ram_addr),
        .o_RAM_DOUT        (ram_dout),
        .i_RAM_DIN         (ram_din),
        .o_RAM_CS_n        (ram_cs_n),
        .o_RAM_WE_n        (ram_we_n)
    );

    int errors = 0;
    int checks = 0;
    int tick_no = 0;

    // Reference model: a CPU access is a timeline anchored at its start tick.
    bit [7:0]    m_mem [0:8191];
    bit          m_busy;
    int          m_start;
    logic [12:0] m_last_addr;
    bit          m_dvalid;
    logic [7:0]  m_ren_dout;
    logic [2:0]  m_ren_phase;
    logic [7:0]  m_cpu_dout;

    logic [2:0]  e_phase;
    bit          e_active, e_ren, e_ok, e_cpu, e_strobe, e_ack, e_cs_n, e_we_n;
    int          e_age;
    logic [12:0] e_addr;

    bit ren_mode;
    bit ag_active, ag_acked;
    int ag_hold;
    bit abort_on_strobe, aborted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (tick %0d)", tag, obs, exp, tick_no);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_start = -1; m_last_addr = '0; m_dvalid = 0;
        m_ren_dout = '0; m_ren_phase = '0; m_cpu_dout = '0;
    endtask

    task automatic model_eval();
        e_phase  = h[2:0];
        e_active = (h >= 9'd256) && (v >= V_FIRST) && (v <= V_LAST);
        e_ren    = e_active && (e_phase < 3'd6);
        e_ok     = (e_phase == 3'd6) || (!e_active && (e_phase != 3'd7) && BF);
        if (!m_busy && cpu_req && e_ok) begin
            m_busy  = 1;
            m_start = tick_no;
        end
        e_age    = m_busy ? (tick_no - m_start) : -1;
        e_cpu    = (e_age == 0) || (e_age == 1);
        e_strobe = (e_age == 1);
        e_ack    = (e_age == 2);
        if (e_ren)      e_addr = ren_addr;
        else if (e_cpu) e_addr = cpu_addr;
        else            e_addr = m_last_addr;
        e_cs_n = !(e_ren || e_cpu);
        e_we_n = !(e_strobe && cpu_wr && !e_ren);
    endtask

    task automatic check_tick();
        chk("ram_cs_n",   ram_cs_n,   e_cs_n);
        chk("ram_we_n",   ram_we_n,   e_we_n);
        chk("ram_addr",   ram_addr,   e_addr);
        chk("cpu_ack",    cpu_ack,    e_ack);
        chk("ren_dvalid", ren_dvalid, m_dvalid);
        chk("ren_dout",   ren_dout,   m_ren_dout);
        chk("ren_phase",  ren_phase,  m_ren_phase);
        chk("cpu_dout",   cpu_dout,   m_cpu_dout);
        if (e_cpu && !e_ren) chk("ram_dout", ram_dout, cpu_din);
    endtask

    task automatic model_commit();
        if (e_ren) begin
            m_dvalid    = 1;
            m_ren_dout  = m_mem[ren_addr];
            m_ren_phase = e_phase;
        end else begin
            m_dvalid = 0;
        end
        if (e_strobe && !e_ren) begin
            if (cpu_wr) m_mem[cpu_addr] = cpu_din;
            else        m_cpu_dout = m_mem[cpu_addr];
        end
        m_last_addr = e_addr;
        if (m_busy && (e_age >= 3) && !cpu_req) m_busy = 0;
    endtask

    task automatic advance();
        if (h == 9'd511) begin
            h = 9'd128;
            v = v + 9'd1;
        end else begin
            h = h + 9'd1;
        end
        ren_addr = ren_mode ? (13'h100 + 13'(h[2:0])) : 13'($urandom);
        if (ag_active && !ag_acked && e_ack) begin
            ag_acked = 1;
            ag_hold  = $urandom_range(0, 2);
        end
        if (ag_acked) begin
            if (ag_hold == 0) begin
                cpu_req = 0; ag_active = 0; ag_acked = 0;
            end else begin
                ag_hold--;
            end
        end
        if (!ag_active) begin
            cpu_wr   = 1'($urandom);
            cpu_addr = 13'($urandom);
            cpu_din  = 8'($urandom);
        end
    endtask

    // One pixel tick: one idle master clock, then one enabled master clock.
    task automatic tick();
        bit          wr_pend;
        logic [12:0] wa;
        logic [7:0]  wd;
        cen_n = 1'b1;
        @(posedge clk); #1;
        cen_n = 1'b0;
        model_eval();
        @(negedge clk);
        check_tick();
        wr_pend = !ram_cs_n && !ram_we_n;
        wa = ram_addr;
        wd = ram_dout;
        if (abort_on_strobe && e_strobe && cpu_wr) begin
            rst_n = 1'b0;
            #1;
            chk("abort_we_n", ram_we_n, 1'b1);
            chk("abort_cs_n", ram_cs_n, 1'b1);
            chk("abort_ack",  cpu_ack,  1'b0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            cen_n = 1'b1;
            model_reset();
            abort_on_strobe = 0; aborted = 1;
            cpu_req = 0; ag_active = 0; ag_acked = 0;
        end else begin
            @(posedge clk); #1;
            cen_n = 1'b1;
            if (wr_pend) ram[wa] = wd;
            model_commit();
        end
        tick_no++;
        advance();
    endtask

    task automatic set_pos(input logic [8:0] hh, input logic [8:0] vv);
        h = hh;
        v = vv;
        ren_addr = ren_mode ? (13'h100 + 13'(h[2:0])) : 13'($urandom);
    endtask

    task automatic cpu_request(input bit wr, input logic [12:0] a, input logic [7:0] d);
        cpu_req = 1; cpu_wr = wr; cpu_addr = a; cpu_din = d;
        ag_active = 1; ag_acked = 0;
    endtask

    task automatic wait_done();
        bit done;
        for (int i = 0; i < 64 && (ag_active || m_busy); i++) tick();
        done = !(ag_active || m_busy);
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL cpu_timeout: observed=busy expected=idle (tick %0d)", tick_no);
        end
    endtask

    initial begin
        logic [8:0] vtab [6];
        logic [12:0] keep_addr;
        vtab[0] = 9'd100;  vtab[1] = 9'd300;
        vtab[2] = V_FIRST - 9'd1; vtab[3] = V_FIRST;
        vtab[4] = V_LAST;  vtab[5] = V_LAST + 9'd1;

        for (int unsigned i = 0; i < 8192; i++) begin
            ram[i]   = 8'(i) ^ 8'(i >> 8);
            m_mem[i] = ram[i];
        end
        ren_mode = 1; ag_active = 0; ag_acked = 0; ag_hold = 0;
        abort_on_strobe = 0; aborted = 0;
        model_reset();

        // Reset values, with a renderer slot and then a CPU start slot presented.
        rst_n = 1'b0; cen_n = 1'b0;
        h = 9'd256; v = 9'd300; ren_addr = 13'h155;
        cpu_req = 0; cpu_wr = 0; cpu_addr = 13'h0AA; cpu_din = 8'h5A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n",      ram_cs_n,   1'b1);
        chk("rst_we_n",      ram_we_n,   1'b1);
        chk("rst_addr",      ram_addr,   13'h0);
        chk("rst_ack",       cpu_ack,    1'b0);
        chk("rst_dvalid",    ren_dvalid, 1'b0);
        chk("rst_ren_dout",  ren_dout,   8'h0);
        chk("rst_ren_phase", ren_phase,  3'h0);
        chk("rst_cpu_dout",  cpu_dout,   8'h0);
        h = 9'd262; cpu_req = 1; cpu_wr = 1;
        @(negedge clk);
        chk("rst_cpu_cs_n",  ram_cs_n,   1'b1);
        chk("rst_cpu_we_n",  ram_we_n,   1'b1);
        cpu_req = 0;
        @(posedge clk); #1;
        rst_n = 1'b1; cen_n = 1'b1;

        // Active line, renderer only.
        set_pos(9'd256, 9'd300);
        repeat (16) tick();

        // Active line CPU write requested at phase 1, then read it back.
        for (int i = 0; i < 8 && h[2:0] != 3'd1; i++) tick();
        cpu_request(1'b1, 13'h0123, 8'hA5);
        wait_done();
        repeat (4) tick();
        cpu_request(1'b0, 13'h0123, 8'h00);
        wait_done();

        // Blank: read requested at phase 2, and at phase 7.
        ren_mode = 0;
        set_pos(9'd130, 9'd100);
        cpu_request(1'b0, 13'($urandom), 8'h00);
        wait_done();
        set_pos(9'd135, 9'd100);
        cpu_request(1'b0, 13'($urandom), 8'h00);
        wait_done();

        // Blank-to-active edge: request at phase 5 of the last blank group.
        set_pos(9'd253, 9'd300);
        cpu_request(1'b1, 13'($urandom), 8'($urandom));
        wait_done();
        repeat (10) tick();

        // Random accesses across blank, active and the V window edges.
        for (int n = 0; n < 24; n++) begin
            set_pos(9'(128 + $urandom_range(0, 383)), vtab[$urandom_range(0, 5)]);
            repeat ($urandom_range(0, 9)) tick();
            cpu_request(1'($urandom), 13'($urandom), 8'($urandom));
            wait_done();
        end

        // Reset during the strobe of a write: no ack, no write, FSM back in IDLE.
        keep_addr = 13'h0777;
        set_pos(9'd262, 9'd300);
        abort_on_strobe = 1;
        cpu_request(1'b1, keep_addr, 8'h3C);
        for (int i = 0; i < 32 && abort_on_strobe; i++) tick();
        checks++;
        assert (aborted) else begin
            errors++;
            $error("FAIL abort_reached: observed=no strobe expected=strobe (tick %0d)", tick_no);
        end
        repeat (6) tick();
        cpu_request(1'b0, keep_addr, 8'h00);
        wait_done();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
